ram_reader: RTL and testbench
=============================

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of RAM words and output data.
REQ-002 Parameter DEPTH, 8, RAM entries; ADDR_WIDTH = clog2(DEPTH) = 3 (derived localparam).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a burst read; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_WIDTH  first RAM address of the burst.
REQ-007 len  input  ADDR_WIDTH+1  number of words to read.
REQ-008 ram_en  output  1  RAM enable.
REQ-009 ram_we  output  1  RAM write enable; constant 0.
REQ-010 ram_addr  output  ADDR_WIDTH  RAM read address.
REQ-011 ram_do  input  DATA_WIDTH  RAM registered read data, valid the cycle after ram_en=1.
REQ-012 out_data  output  DATA_WIDTH  streamed word.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 out_last  output  1  marks final word of burst, qualified by out_valid.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at burst end.

Function
REQ-018 FSM states IDLE, REQ, CAP, SEND, DONE; all outputs registered.
REQ-019 IDLE: start=1 with len=0 -> DONE; start=1 with len>=1 -> REQ, latching cur_addr=start_addr and remaining=min(len, DEPTH).
REQ-020 REQ: ram_en=1, ram_addr=cur_addr for exactly one cycle -> CAP.
REQ-021 CAP: ram_en=0; at end of cycle out_data<=ram_do, out_last<=(remaining==1), out_valid<=1 -> SEND.
REQ-022 SEND: out_data, out_last held stable while out_valid=1 and out_ready=0; no RAM access issued.
REQ-023 SEND handshake (out_valid&out_ready at edge): out_valid<=0; if out_last -> DONE, else cur_addr<=cur_addr+1 mod DEPTH, remaining-=1 -> REQ.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 Latency: start sampled at edge E -> out_valid first high in cycle E+3; with out_ready=1 one word per 3 cycles.
REQ-026 Address wraps from DEPTH-1 to 0.
REQ-027 len > DEPTH clamped to DEPTH; len=0 produces no RAM access and no out_valid, only done.
REQ-028 start asserted outside IDLE ignored, including in the DONE cycle.
REQ-029 ram_we is 0 in every cycle including reset.

Reset
REQ-030 reset=1 at a rising edge forces IDLE from any state, aborting any burst without done.
REQ-031 Reset values: ram_en=0, ram_we=0, ram_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, cur_addr=0, remaining=0.
REQ-032 reset has priority over start and handshake in the same cycle.

Structure
REQ-033 Shared package ram_pkg holds DEPTH, ADDR_WIDTH and the FSM state encoding constants.
REQ-034 Single module, no sub-module; FSM plus address/remaining counters plus output register.

Verification
REQ-035 RAM model (8x8, shift-on-write) pre-loaded by writing 0x11..0x88 in order (ram[0]=0x88, ram[7]=0x11); start_addr=0, len=8, out_ready=1 -> out_data 0x88,0x77,...,0x11, 3 cycles apart, out_last only on 0x11, done one cycle after last handshake.
REQ-036 Wrap: start_addr=6, len=4 -> 0x22,0x11,0x88,0x77; ram_addr sequence 6,7,0,1.
REQ-037 Backpressure: out_ready=0 for 5 cycles during first SEND -> out_data=0x88 and out_valid stable, ram_en=0 throughout; sequence resumes unchanged.
REQ-038 len=0 -> done pulse in cycle after start sample, busy high that cycle only, no ram_en, no out_valid; len=12 -> exactly 8 words.
REQ-039 start pulsed while busy -> ignored, burst completes unchanged; reset in CAP -> next cycle all outputs at reset values, no done, new start accepted normally.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared RAM geometry and burst reader FSM encoding
package ram_pkg;
  localparam int DEPTH = 8;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, REQ, CAP, SEND, DONE} state_t;
endpackage

// File: rtl/ram_reader.sv
// ram_reader: burst reader streaming words from a registered-output RAM over a valid/ready port
module ram_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  import ram_pkg::*;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH:0] rem_q, rem_d, len_clamped;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
  assign len_clamped = (len > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : len;
  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    rem_d = rem_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = (len == '0) ? DONE : REQ;
        cur_addr_d = (len == '0) ? cur_addr_q : start_addr;
        rem_d = (len == '0) ? rem_q : len_clamped;
      end
      REQ: state_d = CAP;
      CAP: begin
        data_d = ram_do;
        last_d = rem_q == (ADDR_WIDTH+1)'(1);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
        valid_d = 1'b0;
        state_d = last_q ? DONE : REQ;
        cur_addr_d = last_q ? cur_addr_q
                   : (cur_addr_q == ADDR_WIDTH'(DEPTH-1)) ? '0 : cur_addr_q + 1'b1;
        rem_d = last_q ? rem_q : rem_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // strobes are registered copies of the upcoming state so they align with it
    en_d = state_d == REQ;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q <= rem_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      en_q <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign ram_en = en_q;
  assign ram_we = 1'b0;
  assign ram_addr = cur_addr_q;
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign out_last = last_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: table-driven bursts against a shift-loaded 8x8 RAM model plus reset corner cases
module tb_ram_reader;
  logic clock = 1'b0;
  logic reset, start, out_ready, ram_en, ram_we, out_valid, out_last, busy, done;
  logic [2:0] start_addr, ram_addr;
  logic [3:0] len;
  logic [7:0] ram_do, out_data;
  logic [7:0] mem [8];
  logic tb_we;
  logic [7:0] tb_din;
  int checks = 0, fails = 0;
  typedef struct {
    logic [2:0] sa;
    logic [3:0] len;
    int stall;
    bit noise;
    int n;
  } vec_t;
  vec_t v [8];
  always #5 clock = ~clock;
  ram_reader #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_do(ram_do),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );
  always @(posedge clock) begin
    if (tb_we | ram_we) begin
      for (int i = 7; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= tb_din;
    end
    if (ram_en) ram_do <= mem[ram_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clock) chk("ram_we_zero", {31'd0, ram_we}, 32'd0);
  function automatic logic [7:0] word_at(input int a);
    return 8'(8'h88 - 8'h11 * (a % 8));
  endfunction
  task automatic burst(input vec_t t);
    int cyc, ens, words, stall;
    bit got_done;
    @(negedge clock);
    start = 1'b1;
    start_addr = t.sa;
    len = t.len;
    out_ready = (t.stall == 0);
    @(posedge clock);
    #1;
    start = t.noise;
    if (t.noise) begin
      start_addr = 3'd3;
      len = 4'd2;
    end
    stall = t.stall;
    cyc = 0;
    ens = 0;
    words = 0;
    got_done = 0;
    chk("busy_after_start", busy, 1);
    while (!got_done && cyc < 200) begin
      if (ram_en) begin
        chk("ram_addr", ram_addr, (t.sa + ens) % 8);
        chk("ram_en_cycle", cyc, 3 * ens + (ens > 0 ? t.stall : 0));
        ens++;
      end
      if (out_valid) begin
        if (stall > 0) begin
          chk("stall_data", out_data, word_at(t.sa));
          chk("stall_last", out_last, t.n == 1);
          chk("stall_no_ram_en", ram_en, 0);
          stall--;
        end else begin
          out_ready = 1'b1;
          chk("out_data", out_data, word_at(t.sa + words));
          chk("out_last", out_last, words == t.n - 1);
          chk("valid_cycle", cyc, 3 * words + 2 + t.stall);
          words++;
        end
      end
      if (done) begin
        got_done = 1;
        chk("done_cycle", cyc, 3 * t.n + t.stall);
      end
      if (!got_done) begin
        @(posedge clock);
        #1;
        cyc++;
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    chk("ram_en_count", ens, t.n);
    chk("word_count", words, t.n);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("idle_after_done", {busy, done}, 0);
    @(posedge clock);
    #1;
    chk("start_in_done_ignored", busy, 0);
  endtask
  initial begin
    v[0] = '{sa: 3'd0, len: 4'd8,  stall: 0, noise: 0, n: 8};
    v[1] = '{sa: 3'd6, len: 4'd4,  stall: 0, noise: 0, n: 4};
    v[2] = '{sa: 3'd0, len: 4'd8,  stall: 5, noise: 0, n: 8};
    v[3] = '{sa: 3'd0, len: 4'd0,  stall: 0, noise: 0, n: 0};
    v[4] = '{sa: 3'd0, len: 4'd12, stall: 0, noise: 0, n: 8};
    v[5] = '{sa: 3'd2, len: 4'd3,  stall: 0, noise: 1, n: 3};
    v[6] = '{sa: 3'd7, len: 4'd1,  stall: 3, noise: 0, n: 1};
    v[7] = '{sa: 3'd5, len: 4'd15, stall: 2, noise: 1, n: 8};
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    len = '0;
    out_ready = 1'b1;
    tb_we = 1'b0;
    tb_din = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {ram_en, ram_we, ram_addr, out_data, out_valid, out_last, busy, done}, 0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      tb_we = 1'b1;
      tb_din = 8'(8'h11 * i);
    end
    @(negedge clock);
    tb_we = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) burst(v[i]);
    // abort a burst in CAP with reset and a competing start in the same cycle
    @(negedge clock);
    start = 1'b1;
    start_addr = 3'd0;
    len = 4'd8;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("abort_req_en", ram_en, 1);
    @(posedge clock);
    #1;
    chk("abort_cap_state", {ram_en, busy}, 2'b01);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_reset_outputs", {ram_en, ram_we, ram_addr, out_data, out_valid, out_last, busy, done}, 0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_no_done", {busy, done}, 0);
    burst(v[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
